// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN expression evaluator:
// operator token codes, error codes and the control FSM state encoding.
package rpn_pkg;

  localparam logic [7:0] OP_ADD = 8'h2B;  // "+"
  localparam logic [7:0] OP_SUB = 8'h2D;  // "-"
  localparam logic [7:0] OP_MUL = 8'h2A;  // "*"
  localparam logic [7:0] OP_DIV = 8'h2F;  // "/"

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_DIV_ZERO  = 3'd3;
  localparam logic [2:0] ERR_BAD_OP    = 3'd4;
  localparam logic [2:0] ERR_MALFORMED = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DIV,
    REL,
    DONE
  } state_t;

  function automatic logic is_known_op(input logic [7:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/rpn_divider.sv
// Iterative restoring divider, one quotient bit per cycle, DATA_W cycles per
// division. The first iteration happens on the start edge itself.
module rpn_divider #(
  parameter int DATA_W = 32,
  parameter int SIGNED = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] den_reg;
  logic              neg_reg;
  logic              run_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [DATA_W-1:0] rem_src;
  logic [DATA_W-1:0] quo_src;
  logic [DATA_W-1:0] den_src;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  // Work on magnitudes; the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  assign a_neg = (SIGNED != 0) && dividend[DATA_W-1];
  assign b_neg = (SIGNED != 0) && divisor[DATA_W-1];
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  always_comb begin
    rem_src  = start ? '0 : rem_reg;
    quo_src  = start ? a_mag : quo_reg;
    den_src  = start ? b_mag : den_reg;
    shifted  = {rem_src, quo_src[DATA_W-1]};
    trial    = shifted - {1'b0, den_src};
    fits     = ~trial[DATA_W];
    rem_next = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next = {quo_src[DATA_W-2:0], fits};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      den_reg  <= '0;
      neg_reg  <= 1'b0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        den_reg <= b_mag;
        neg_reg <= a_neg ^ b_neg;
        cnt_reg <= CNT_W'(DATA_W - 1);
        run_reg <= 1'b1;
      end else if (run_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done     = done_reg;
  assign quotient = neg_reg ? (~quo_reg + 1'b1) : quo_reg;

endmodule

// File: rtl/rpn_eval.sv
// Reverse-Polish expression evaluator: strobe-handshaken number/operator
// tokens feed an operand stack; the end marker reports the result and error.
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int SIGNED = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] INPUT_NUMBER,
  input  logic              NUMBER_STB,
  input  logic [7:0]        INPUT_SIGN,
  input  logic              SIGN_STB,
  output logic              BUSY,
  output logic [DATA_W-1:0] OUT,
  output logic              OUT_STB,
  output logic [2:0]        ERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] stack_reg [DEPTH];
  logic [CNT_W-1:0]  count_reg;

  state_t            state_reg;
  logic              tok_num_reg;
  logic [DATA_W-1:0] tok_val_reg;
  logic [7:0]        tok_op_reg;
  logic [2:0]        err_reg;
  logic [2:0]        err_out_reg;
  logic              busy_reg;
  logic              out_stb_reg;
  logic [DATA_W-1:0] out_reg;

  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  sec_idx;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic              stack_full;
  logic              has_two;
  logic              known_op;
  logic              is_div_op;
  logic              exec_live;
  logic              push_en;
  logic              alu_en;
  logic              div_start;
  logic              div_wr;
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        exec_err;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  // b is the top of stack, a the entry below it.
  assign top_idx    = PTR_W'(count_reg - CNT_W'(1));
  assign sec_idx    = PTR_W'(count_reg - CNT_W'(2));
  assign b_val      = stack_reg[top_idx];
  assign a_val      = stack_reg[sec_idx];
  assign stack_full = (count_reg == CNT_W'(DEPTH));
  assign has_two    = (count_reg >= CNT_W'(2));
  assign known_op   = is_known_op(tok_op_reg);
  assign is_div_op  = (tok_op_reg == OP_DIV);

  // Once an error is latched, tokens are acknowledged but have no effect.
  assign exec_live = (state_reg == EXEC) && (err_reg == ERR_NONE);
  assign push_en   = exec_live && tok_num_reg && !stack_full;
  assign alu_en    = exec_live && !tok_num_reg && known_op && !is_div_op && has_two;
  assign div_start = exec_live && !tok_num_reg && is_div_op && has_two && (b_val != '0);
  assign div_wr    = (state_reg == DIV) && div_done;

  always_comb begin
    alu_res = '0;
    case (tok_op_reg)
      OP_ADD:  alu_res = a_val + b_val;
      OP_SUB:  alu_res = a_val - b_val;
      OP_MUL:  alu_res = a_val * b_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    exec_err = ERR_NONE;
    if (exec_live) begin
      if (tok_num_reg) begin
        if (stack_full) exec_err = ERR_OVERFLOW;
      end else if (!known_op) begin
        exec_err = ERR_BAD_OP;
      end else if (!has_two) begin
        exec_err = ERR_UNDERFLOW;
      end else if (is_div_op && (b_val == '0)) begin
        exec_err = ERR_DIV_ZERO;
      end
    end
  end

  // Binary ops overwrite a's slot and drop b; pushes land just above top.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (push_en) begin
      wr_en   = 1'b1;
      wr_idx  = PTR_W'(count_reg);
      wr_data = tok_val_reg;
    end else if (alu_en) begin
      wr_en   = 1'b1;
      wr_idx  = sec_idx;
      wr_data = alu_res;
    end else if (div_wr) begin
      wr_en   = 1'b1;
      wr_idx  = sec_idx;
      wr_data = div_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      stack_reg[wr_idx] <= wr_data;
    end
  end

  rpn_divider #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (a_val),
    .divisor  (b_val),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      tok_num_reg <= 1'b0;
      tok_val_reg <= '0;
      tok_op_reg  <= '0;
      err_reg     <= ERR_NONE;
      err_out_reg <= ERR_NONE;
      busy_reg    <= 1'b0;
      out_stb_reg <= 1'b0;
      out_reg     <= '0;
      count_reg   <= '0;
    end else begin
      out_stb_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // BUSY falls one cycle after leaving REL, so a strobe that is
          // still visible in that cycle is never taken as a fresh token.
          if (busy_reg) begin
            busy_reg <= 1'b0;
          end else if (NUMBER_STB && SIGN_STB) begin
            state_reg <= DONE;
            busy_reg  <= 1'b1;
          end else if (NUMBER_STB || SIGN_STB) begin
            tok_num_reg <= NUMBER_STB;
            tok_val_reg <= INPUT_NUMBER;
            tok_op_reg  <= INPUT_SIGN;
            state_reg   <= EXEC;
            busy_reg    <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_err != ERR_NONE) err_reg <= exec_err;
          if (push_en) count_reg <= count_reg + 1'b1;
          if (alu_en) count_reg <= count_reg - 1'b1;
          state_reg <= div_start ? DIV : REL;
        end
        DIV: begin
          if (div_done) begin
            count_reg <= count_reg - 1'b1;
            state_reg <= REL;
          end
        end
        DONE: begin
          out_stb_reg <= 1'b1;
          out_reg     <= (count_reg == '0) ? '0 : b_val;
          err_out_reg <= ((err_reg == ERR_NONE) && (count_reg != CNT_W'(1))) ? ERR_MALFORMED : err_reg;
          count_reg   <= '0;
          err_reg     <= ERR_NONE;
          state_reg   <= REL;
        end
        REL: begin
          if (!NUMBER_STB && !SIGN_STB) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY    = busy_reg;
  assign OUT     = out_reg;
  assign OUT_STB = out_stb_reg;
  assign ERR     = err_out_reg;

endmodule

// File: tb/tb_rpn_eval.sv
// Self-checking bench for rpn_eval: two instances (DEPTH 16 and 4) share one
// token stream; hand tables, corner sequences and a random stream vs. a model.
module tb_rpn_eval;

  localparam int K_NUM = 0;
  localparam int K_OP  = 1;
  localparam int K_END = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INPUT_NUMBER = '0;
  logic        NUMBER_STB = 1'b0;
  logic [7:0]  INPUT_SIGN = '0;
  logic        SIGN_STB = 1'b0;

  logic        busy16, out_stb16, busy4, out_stb4;
  logic [31:0] out16, out4;
  logic [2:0]  err16, err4;

  rpn_eval #(.DATA_W(32), .DEPTH(16), .SIGNED(1)) dut (
    .CLK(CLK), .RST(RST), .INPUT_NUMBER(INPUT_NUMBER), .NUMBER_STB(NUMBER_STB),
    .INPUT_SIGN(INPUT_SIGN), .SIGN_STB(SIGN_STB), .BUSY(busy16), .OUT(out16),
    .OUT_STB(out_stb16), .ERR(err16));

  rpn_eval #(.DATA_W(32), .DEPTH(4), .SIGNED(1)) dut4 (
    .CLK(CLK), .RST(RST), .INPUT_NUMBER(INPUT_NUMBER), .NUMBER_STB(NUMBER_STB),
    .INPUT_SIGN(INPUT_SIGN), .SIGN_STB(SIGN_STB), .BUSY(busy4), .OUT(out4),
    .OUT_STB(out_stb4), .ERR(err4));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result pulse capture, sampled away from the active edge.
  int          stb_cnt [2] = '{0, 0};
  logic [31:0] cap_out [2];
  logic [2:0]  cap_err [2];

  always @(negedge CLK) begin
    if (out_stb16) begin stb_cnt[0]++; cap_out[0] = out16; cap_err[0] = err16; end
    if (out_stb4)  begin stb_cnt[1]++; cap_out[1] = out4;  cap_err[1] = err4;  end
  end

  // Behavioural model: plain stack arithmetic, index 0 = DEPTH 16, 1 = DEPTH 4.
  logic [31:0] m_stk [2][256];
  int          m_cnt [2] = '{0, 0};
  logic [2:0]  m_err [2] = '{3'd0, 3'd0};
  logic [31:0] m_out [2];
  logic [2:0]  m_eout [2];

  task automatic model_step(input int d, input int kind, input logic [31:0] v,
                            input logic [7:0] op, output int busy);
    int depth;
    logic [31:0] a, b, r;
    longint q;
    depth = (d == 0) ? 16 : 4;
    busy = 3;
    if (kind == K_END) begin
      m_out[d]  = (m_cnt[d] == 0) ? 32'd0 : m_stk[d][m_cnt[d]-1];
      m_eout[d] = (m_err[d] != 0) ? m_err[d] : ((m_cnt[d] != 1) ? 3'd5 : 3'd0);
      m_cnt[d] = 0;
      m_err[d] = 0;
    end else if (m_err[d] != 0) begin
      busy = 3;
    end else if (kind == K_NUM) begin
      if (m_cnt[d] == depth) m_err[d] = 3'd1;
      else begin m_stk[d][m_cnt[d]] = v; m_cnt[d]++; end
    end else if (!(op == 8'h2B || op == 8'h2D || op == 8'h2A || op == 8'h2F)) begin
      m_err[d] = 3'd4;
    end else if (m_cnt[d] < 2) begin
      m_err[d] = 3'd2;
    end else begin
      b = m_stk[d][m_cnt[d]-1];
      a = m_stk[d][m_cnt[d]-2];
      r = 32'd0;
      if (op == 8'h2F && b == 32'd0) begin
        m_err[d] = 3'd3;
      end else begin
        if (op == 8'h2B) r = a + b;
        else if (op == 8'h2D) r = a - b;
        else if (op == 8'h2A) r = a * b;
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = q[31:0];
          busy = 35;
        end
        m_cnt[d]--;
        m_stk[d][m_cnt[d]-1] = r;
      end
    end
  endtask

  // Present one token, drop the strobe when both BUSYs are seen (or after
  // 'hold' cycles), and count the cycles each BUSY stayed high.
  task automatic send(input int kind, input logic [31:0] v, input logic [7:0] op,
                      input int hold, output int b16, output int b4);
    int held;
    bit dropped;
    bit fin;
    held = 0; dropped = 0; fin = 0; b16 = 0; b4 = 0;
    @(negedge CLK);
    INPUT_NUMBER = v;
    INPUT_SIGN   = op;
    NUMBER_STB   = (kind != K_OP);
    SIGN_STB     = (kind != K_NUM);
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge CLK);
      if (busy16) b16++;
      if (busy4) b4++;
      if (!dropped) begin
        held++;
        if ((hold == 0 && busy16 && busy4) || (hold > 0 && held >= hold)) begin
          NUMBER_STB = 1'b0;
          SIGN_STB   = 1'b0;
          dropped    = 1;
        end
      end else if (!busy16 && !busy4) begin
        fin = 1;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got busy=%0b/%0b, expected both low", busy16, busy4);
      NUMBER_STB = 1'b0;
      SIGN_STB   = 1'b0;
    end
  endtask

  task automatic do_token(input int kind, input logic [31:0] v, input logic [7:0] op);
    int e16, e4, b16, b4, s0, s1;
    model_step(0, kind, v, op, e16);
    model_step(1, kind, v, op, e4);
    s0 = stb_cnt[0];
    s1 = stb_cnt[1];
    send(kind, v, op, 0, b16, b4);
    check("busy_cycles16", b16, e16);
    check("busy_cycles4", b4, e4);
    check("out_stb_count16", stb_cnt[0] - s0, (kind == K_END) ? 1 : 0);
    check("out_stb_count4", stb_cnt[1] - s1, (kind == K_END) ? 1 : 0);
    if (kind == K_END) begin
      check("out16", cap_out[0], m_out[0]);
      check("err16", cap_err[0], m_eout[0]);
      check("out4", cap_out[1], m_out[1]);
      check("err4", cap_err[1], m_eout[1]);
      $display("expr: out16=%h err16=%0d out4=%h err4=%0d", cap_out[0], cap_err[0], cap_out[1], cap_err[1]);
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [7:0]  op;
    int          exp_busy;
    logic [31:0] exp_out16;
    logic [31:0] exp_out4;
    logic [2:0]  exp_err16;
    logic [2:0]  exp_err4;
  } vec_t;

  vec_t vecs[$];

  task automatic addn(input logic [31:0] v);
    vecs.push_back('{K_NUM, v, 8'h00, 3, 32'd0, 32'd0, 3'd0, 3'd0});
  endtask
  task automatic addo(input logic [7:0] op, input int busy);
    vecs.push_back('{K_OP, 32'd0, op, busy, 32'd0, 32'd0, 3'd0, 3'd0});
  endtask
  task automatic adde(input logic [31:0] o16, input logic [31:0] o4, input logic [2:0] e16, input logic [2:0] e4);
    vecs.push_back('{K_END, 32'd0, 8'h00, 3, o16, o4, e16, e4});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b16, b4, s0, s1;
    logic [31:0] v;
    logic [7:0]  op;

    // Hand-computed expressions.
    addn(3); addn(4); addo("+", 3); addn(2); addo("*", 3); adde(14, 14, 0, 0);
    addn(7); addn(32'hFFFFFFFE); addo("/", 35); adde(32'hFFFFFFFD, 32'hFFFFFFFD, 0, 0);
    addn(5); addn(0); addo("/", 3); addn(1); adde(0, 0, 3, 3);
    addn(2); addn(2); addo("+", 3); adde(4, 4, 0, 0);
    addn(1); addn(2); addn(3); addn(4); addn(5); adde(5, 4, 5, 1);
    addo("+", 3); adde(0, 0, 2, 2);
    addn(1); addn(2); adde(2, 2, 5, 5);
    addn(1); addn(2); addo("%", 3); adde(2, 2, 4, 4);
    addn(32'hFFFFFFF9); addn(2); addo("/", 35); adde(32'hFFFFFFFD, 32'hFFFFFFFD, 0, 0);
    addn(32'h10000); addn(32'h10000); addo("*", 3); adde(0, 0, 0, 0);
    addn(0); addn(1); addo("-", 3); adde(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    addn(32'h80000000); addn(32'hFFFFFFFF); addo("/", 35); adde(32'h80000000, 32'h80000000, 0, 0);
    addn(100); addn(7); addo("/", 35); addn(3); addo("-", 3); adde(11, 11, 0, 0);

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset_busy16", busy16, 0);
    check("reset_busy4", busy4, 0);
    check("reset_out16", out16, 0);
    check("reset_out_stb16", out_stb16, 0);
    check("reset_err16", err16, 0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      s0 = stb_cnt[0];
      s1 = stb_cnt[1];
      send(vecs[i].kind, vecs[i].val, vecs[i].op, 0, b16, b4);
      check($sformatf("vec%0d_busy16", i), b16, vecs[i].exp_busy);
      check($sformatf("vec%0d_busy4", i), b4, vecs[i].exp_busy);
      if (vecs[i].kind == K_END) begin
        check($sformatf("vec%0d_stb16", i), stb_cnt[0] - s0, 1);
        check($sformatf("vec%0d_stb4", i), stb_cnt[1] - s1, 1);
        check($sformatf("vec%0d_out16", i), cap_out[0], vecs[i].exp_out16);
        check($sformatf("vec%0d_err16", i), cap_err[0], vecs[i].exp_err16);
        check($sformatf("vec%0d_out4", i), cap_out[1], vecs[i].exp_out4);
        check($sformatf("vec%0d_err4", i), cap_err[1], vecs[i].exp_err4);
        $display("vec %0d: out16=%h err16=%0d out4=%h err4=%0d", i, cap_out[0], cap_err[0], cap_out[1], cap_err[1]);
      end
    end

    // Strobe held for 6 cycles: one token only, BUSY until the strobe falls.
    send(K_NUM, 32'd42, 8'h00, 6, b16, b4);
    check("hold_busy16", b16, 7);
    check("hold_busy4", b4, 7);
    s0 = stb_cnt[0];
    send(K_END, 32'd0, 8'h00, 0, b16, b4);
    check("hold_stb16", stb_cnt[0] - s0, 1);
    check("hold_out16", cap_out[0], 42);
    check("hold_err16", cap_err[0], 0);
    $display("hold: out16=%h err16=%0d", cap_out[0], cap_err[0]);

    // Reset in the middle of a division, with a strobe present on the reset edge.
    do_token(K_NUM, 32'd7, 8'h00);
    do_token(K_NUM, 32'd2, 8'h00);
    @(negedge CLK);
    INPUT_SIGN = 8'h2F;
    SIGN_STB   = 1'b1;
    for (int i = 0; i < 20 && !busy16; i++) @(negedge CLK);
    SIGN_STB = 1'b0;
    repeat (10) @(negedge CLK);
    check("middiv_busy_before_rst", busy16, 1);
    RST = 1'b1;
    NUMBER_STB = 1'b1;
    INPUT_NUMBER = 32'd77;
    @(negedge CLK);
    check("rst_busy16", busy16, 0);
    check("rst_busy4", busy4, 0);
    check("rst_out16", out16, 0);
    check("rst_err16", err16, 0);
    RST = 1'b0;
    NUMBER_STB = 1'b0;
    repeat (2) @(negedge CLK);
    check("post_rst_busy16", busy16, 0);
    m_cnt = '{0, 0};
    m_err = '{3'd0, 3'd0};
    do_token(K_NUM, 32'd9, 8'h00);
    do_token(K_END, 32'd0, 8'h00);
    check("rst_then_9_out16", cap_out[0], 9);
    check("rst_then_9_err16", cap_err[0], 0);
    $display("reset mid-div: out16=%h err16=%0d", cap_out[0], cap_err[0]);

    // Random expressions against the model.
    for (int e = 0; e < 40; e++) begin
      int ntok;
      ntok = $urandom_range(1, 7);
      for (int t = 0; t < ntok; t++) begin
        int r;
        int s;
        r = $urandom_range(0, 99);
        if (r < 55) begin
          v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
          do_token(K_NUM, v, 8'h00);
        end else begin
          s = $urandom_range(0, 19);
          op = (s < 5) ? 8'h2B : (s < 10) ? 8'h2D : (s < 14) ? 8'h2A : (s < 19) ? 8'h2F : 8'h3F;
          do_token(K_OP, 32'd0, op);
        end
      end
      do_token(K_END, 32'd0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rpn_eval.md
RPN_EVAL -- requirements
Module: rpn_eval

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (range 8..64).
REQ-002 SHALL have parameter DEPTH, default 16, operand stack entries (power of two, 4..256).
REQ-003 SHALL have parameter SIGNED, default 1; 1 = two's-complement division, 0 = unsigned.
REQ-004 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port INPUT_NUMBER  input  DATA_W  operand token value.
REQ-007 SHALL have port NUMBER_STB  input  1  operand token valid, held by source until BUSY seen.
REQ-008 SHALL have port INPUT_SIGN  input  8  ASCII operator token: "+", "-", "*", "/".
REQ-009 SHALL have port SIGN_STB  input  1  operator token valid, held by source until BUSY seen.
REQ-010 SHALL have port BUSY  output  1  high while a token is processing or its strobe is still high.
REQ-011 SHALL have port OUT  output  DATA_W  final expression result.
REQ-012 SHALL have port OUT_STB  output  1  one-cycle pulse, OUT and ERR valid.
REQ-013 SHALL have port ERR  output  3  error code accompanying OUT_STB (0 = none).

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DIV, REL, DONE.
REQ-015 In IDLE with exactly one strobe high, SHALL latch the token, go to EXEC, and drive BUSY=1 from the next cycle.
REQ-016 Both strobes high in the same IDLE cycle SHALL be the end-of-expression marker, going to DONE.
REQ-017 EXEC number: push INPUT_NUMBER in one cycle; stack full (count==DEPTH) sets ERR=1 (overflow), no push.
REQ-018 EXEC operator: fewer than 2 entries sets ERR=2 (underflow); otherwise pop b (top), pop a, push a op b.
REQ-019 "+", "-", "*" SHALL complete in one EXEC cycle, result truncated modulo 2^DATA_W.
REQ-020 "/" SHALL enter DIV for exactly DATA_W cycles, quotient truncated toward zero; b==0 sets ERR=3, pushes nothing, skips DIV.
REQ-021 Unknown INPUT_SIGN code SHALL set ERR=4 and leave the stack unchanged.
REQ-022 ERR SHALL be sticky: after the first error, later tokens are handshaken but ignored until the end marker.
REQ-023 After EXEC/DIV, SHALL go to REL and hold BUSY=1 until both strobes are low, then return to IDLE.
REQ-024 DONE: stack count != 1 with ERR==0 sets ERR=5 (malformed); SHALL pulse OUT_STB one cycle with OUT=top (0 if empty).
REQ-025 After DONE, SHALL clear the stack and ERR, then go to REL.
REQ-026 OUT SHALL hold its value between OUT_STB pulses.
REQ-027 Latency from strobe sample to BUSY fall, with strobe dropped on BUSY: push/add/sub/mul 3 cycles; div DATA_W+3.
REQ-028 Strobes asserted while BUSY=1 SHALL NOT be re-accepted as a new token.

Reset
REQ-029 RST SHALL force IDLE, BUSY=0, OUT=0, OUT_STB=0, ERR=0, stack count 0, and divider idle, from the next edge.
REQ-030 RST SHALL take priority over every event, including a DIV in progress or a strobe in the same cycle.

Structure
REQ-031 Package rpn_pkg SHALL hold the operator ASCII constants, the ERR code constants (0..5) and the FSM state typedef.
REQ-032 Division SHALL be a sub-module rpn_divider: iterative restoring, start/done handshake, sign handling per SIGNED.
REQ-033 The stack SHALL be a register array of DEPTH x DATA_W with a $clog2(DEPTH)+1 bit count.

Verification
REQ-034 Tokens 3, 4, "+", 2, "*", end -> one OUT_STB, OUT=14, ERR=0.
REQ-035 SIGNED=1: tokens 7, -2, "/", end -> OUT=-3 (0xFFFFFFFD), ERR=0; BUSY high for 35 cycles on the "/" token.
REQ-036 Tokens 5, 0, "/", 1, end -> OUT_STB with ERR=3; the next expression 2, 2, "+" -> OUT=4, ERR=0.
REQ-037 DEPTH=4: push 5 numbers, end -> ERR=1; separately "+" alone, end -> ERR=2; 1, 2, end -> ERR=5.
REQ-038 RST asserted mid-DIV -> BUSY=0 next cycle; a following 9, end -> OUT=9, ERR=0.
REQ-039 Strobe held 6 cycles -> exactly one token consumed, with BUSY high until the strobe falls.
